// File: rtl/gfx_wbm_readwrite_if.sv
// Request/acknowledge port from the read/write arbiter plus the Wishbone master bus
// of the GFX shared-memory engine; master = engine side, slave = arbiter/memory side.
interface gfx_wbm_readwrite_if #(
  parameter int unsigned MDW = 256
);
  logic             read_request_i;
  logic             write_request_i;
  logic [31:0]      addr_i;
  logic             we_i;
  logic [MDW/8-1:0] sel_i;
  logic [MDW-1:0]   dat_i;
  logic [MDW-1:0]   dat_o;
  logic             ack_o;
  logic             err_o;
  logic             busy_o;
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [31:0]      wbm_adr_o;
  logic [MDW/8-1:0] wbm_sel_o;
  logic [MDW-1:0]   wbm_dat_o;
  logic [MDW-1:0]   wbm_dat_i;
  logic             wbm_ack_i;
  logic             wbm_err_i;

  modport master (
    input  read_request_i, write_request_i, addr_i, we_i, sel_i, dat_i,
    output dat_o, ack_o, err_o, busy_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    output read_request_i, write_request_i, addr_i, we_i, sel_i, dat_i,
    input  dat_o, ack_o, err_o, busy_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/gfx_wbm_readwrite.sv
// Single-transaction Wishbone classic master: one read or write per request, with
// slave errors and bus hangs turned into an acknowledge plus an error pulse.
module gfx_wbm_readwrite #(
  parameter int unsigned MDW     = 256,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  gfx_wbm_readwrite_if.master bus
);

  localparam logic [31:0] ADR_MASK = ~(32'(MDW / 8) - 32'd1);
  localparam bit          TO_EN    = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST  = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        unused_we;

  // Direction comes from which request line is raised; the arbiter's we is advisory.
  assign unused_we = bus.we_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.wbm_cyc_o <= 1'b0;
      bus.wbm_stb_o <= 1'b0;
      bus.wbm_we_o  <= 1'b0;
      bus.wbm_adr_o <= '0;
      bus.wbm_sel_o <= '0;
      bus.wbm_dat_o <= '0;
      bus.dat_o     <= '0;
      bus.ack_o     <= 1'b0;
      bus.err_o     <= 1'b0;
      bus.busy_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.ack_o <= 1'b0;
          bus.err_o <= 1'b0;
          if (bus.read_request_i || bus.write_request_i) begin
            state         <= BUS;
            cnt           <= '0;
            bus.busy_o    <= 1'b1;
            bus.wbm_cyc_o <= 1'b1;
            bus.wbm_stb_o <= 1'b1;
            bus.wbm_we_o  <= bus.write_request_i;
            bus.wbm_adr_o <= bus.addr_i & ADR_MASK;
            bus.wbm_sel_o <= bus.sel_i;
            bus.wbm_dat_o <= bus.dat_i;
          end
        end
        BUS: begin
          if (bus.wbm_err_i || bus.wbm_ack_i || (TO_EN && cnt == TO_LAST)) begin
            state         <= DONE;
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.ack_o     <= 1'b1;
            // err wins over ack; neither present means the timeout expired
            bus.err_o     <= bus.wbm_err_i || !bus.wbm_ack_i;
            if (!bus.wbm_we_o && bus.wbm_ack_i && !bus.wbm_err_i)
              bus.dat_o <= bus.wbm_dat_i;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          state      <= IDLE;
          bus.ack_o  <= 1'b0;
          bus.err_o  <= 1'b0;
          bus.busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_wbm_readwrite.sv
// Directed and randomized transactions against a cycle-count model of the
// gfx_wbm_readwrite engine with a scripted Wishbone slave.
module tb_gfx_wbm_readwrite;
  localparam int unsigned MDW = 256;
  localparam int unsigned SW  = MDW / 8;
  localparam int          TO  = 8;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [MDW-1:0] model_dout = '0;

  gfx_wbm_readwrite_if #(.MDW(MDW)) bus ();

  gfx_wbm_readwrite #(.MDW(MDW), .TIMEOUT(TO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [MDW-1:0] obs, input logic [MDW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drop_req();
    bus.read_request_i  = 1'b0;
    bus.write_request_i = 1'b0;
    bus.we_i            = 1'b0;
  endtask

  // resp: 0 ack, 1 err, 2 silent slave, 3 ack and err together
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [SW-1:0] sel, input logic [MDW-1:0] wdat,
                         input logic [MDW-1:0] rdat, input int waits, input int resp,
                         input bit hold);
    bit             timed_out;
    int             exp_cyc;
    bit             exp_err;
    logic [MDW-1:0] exp_dout;
    int             cyc_cnt = 0;
    int             first_c = -1;
    bit             done = 1'b0;

    timed_out = (resp == 2) || (waits >= TO);
    exp_cyc   = timed_out ? TO : waits + 1;
    exp_err   = timed_out || (resp != 0);
    exp_dout  = (rd && !wr && !timed_out && resp == 0) ? rdat : model_dout;

    @(negedge clk);
    bus.read_request_i  = rd;
    bus.write_request_i = wr;
    bus.we_i            = wr;
    bus.addr_i          = addr;
    bus.sel_i           = sel;
    bus.dat_i           = wdat;
    bus.wbm_dat_i       = rdat;

    for (int c = 0; c < TO + 10 && !done; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) begin
        drop_req();
        bus.addr_i = $urandom;
        bus.sel_i  = ~sel;
        bus.dat_i  = ~wdat;
      end
      bus.wbm_ack_i = 1'b0;
      bus.wbm_err_i = 1'b0;
      if (bus.wbm_cyc_o) begin
        cyc_cnt++;
        if (first_c < 0) begin
          first_c = c;
          chk_i("cyc_start", c, 0);
          chk_i("stb", int'(bus.wbm_stb_o), 1);
          chk_i("busy_bus", int'(bus.busy_o), 1);
          chk_i("adr", int'(bus.wbm_adr_o), int'(addr & 32'hFFFF_FFE0));
          chk_i("we", int'(bus.wbm_we_o), int'(wr));
          chk_i("sel", int'(bus.wbm_sel_o), int'(sel));
          chk("wdat", bus.wbm_dat_o, wdat);
        end
      end
      if (bus.ack_o) begin
        done = 1'b1;
        chk_i("cyc_len", cyc_cnt, exp_cyc);
        chk_i("ack_at", c, exp_cyc);
        chk_i("err", int'(bus.err_o), int'(exp_err));
        chk_i("cyc_in_done", int'(bus.wbm_cyc_o), 0);
        chk_i("busy_done", int'(bus.busy_o), 1);
        chk("dat_o", bus.dat_o, exp_dout);
      end else if (bus.wbm_cyc_o && cyc_cnt == waits + 1) begin
        bus.wbm_ack_i = (resp == 0 || resp == 3);
        bus.wbm_err_i = (resp == 1 || resp == 3);
      end
    end
    chk_i("ack_seen", int'(done), 1);
    model_dout = exp_dout;

    @(negedge clk);
    chk_i("ack_pulse", int'(bus.ack_o), 0);
    chk_i("err_pulse", int'(bus.err_o), 0);
    chk_i("busy_idle", int'(bus.busy_o), 0);
    chk_i("cyc_idle", int'(bus.wbm_cyc_o), 0);
    if (hold) begin
      drop_req();
      @(negedge clk);
      chk_i("no_reissue", int'(bus.wbm_cyc_o), 0);
    end
  endtask

  initial begin
    logic [MDW-1:0] a5;
    logic [MDW-1:0] rnd_w;
    logic [MDW-1:0] rnd_r;
    logic [SW-1:0]  rnd_s;
    bit             rd;
    bit             wr;

    a5 = {SW{8'hA5}};
    drop_req();
    bus.addr_i    = '0;
    bus.sel_i     = '0;
    bus.dat_i     = '0;
    bus.wbm_dat_i = '0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_err_i = 1'b0;

    @(negedge clk);
    chk_i("rst_cyc", int'(bus.wbm_cyc_o), 0);
    chk_i("rst_stb", int'(bus.wbm_stb_o), 0);
    chk_i("rst_ack", int'(bus.ack_o), 0);
    chk_i("rst_busy", int'(bus.busy_o), 0);
    chk_i("rst_adr", int'(bus.wbm_adr_o), 0);
    chk("rst_dat_o", bus.dat_o, '0);
    rst_ni = 1'b1;

    run_txn(1, 0, 32'h0000_1234, '1, '0, a5, 0, 0, 0);
    chk_i("zw_adr", int'(bus.wbm_adr_o), 32'h0000_1220);
    run_txn(0, 1, 32'h0000_0040, SW'(32'h0000_000F), MDW'(1), ~a5, 3, 0, 0);
    run_txn(1, 0, 32'h0000_0080, '1, '0, MDW'(7), 1, 1, 0);
    run_txn(1, 0, 32'h0000_00C0, '1, '0, MDW'(9), 0, 2, 0);
    run_txn(1, 0, 32'h0000_0100, '1, '0, MDW'(42), 2, 0, 0);
    run_txn(1, 1, 32'h0000_0140, '1, MDW'(5), MDW'(99), 0, 0, 1);
    run_txn(1, 0, 32'h0000_0180, '1, '0, MDW'(77), 1, 3, 0);
    run_txn(1, 0, 32'h0000_01C0, '1, '0, MDW'(11), 7, 0, 0);

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < MDW / 32; k++) begin
        rnd_w[k*32 +: 32] = $urandom;
        rnd_r[k*32 +: 32] = $urandom;
      end
      rnd_s = SW'($urandom);
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      run_txn(rd, wr, $urandom, rnd_s, rnd_w, rnd_r,
              int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Reset while the slave is stalling in the middle of a read
    @(negedge clk);
    bus.read_request_i = 1'b1;
    bus.addr_i         = 32'h0000_2000;
    bus.wbm_dat_i      = a5;
    @(negedge clk);
    drop_req();
    @(negedge clk);
    chk_i("pre_rst_cyc", int'(bus.wbm_cyc_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk_i("mrst_cyc", int'(bus.wbm_cyc_o), 0);
    chk_i("mrst_stb", int'(bus.wbm_stb_o), 0);
    chk_i("mrst_ack", int'(bus.ack_o), 0);
    chk_i("mrst_busy", int'(bus.busy_o), 0);
    chk_i("mrst_adr", int'(bus.wbm_adr_o), 0);
    chk("mrst_dat_o", bus.dat_o, '0);
    model_dout = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_i("post_rst_ack", int'(bus.ack_o), 0);
      chk_i("post_rst_cyc", int'(bus.wbm_cyc_o), 0);
    end
    run_txn(1, 0, 32'h0000_2040, '1, '0, a5, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
